// File: rtl/ifetch_unit.sv
// Instruction fetch front end: single-outstanding imem reader feeding a small
// instruction FIFO, with branch redirect, wrong-path flush and misalignment halt.
module ifetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_redirect,
  input  logic [31:0] i_redirect_pc,
  output logic        o_imem_req,
  output logic [31:0] o_imem_addr,
  input  logic        i_imem_rvalid,
  input  logic [31:0] i_imem_rdata,
  output logic        o_instr_vld,
  output logic [31:0] o_instr,
  output logic [31:0] o_pc,
  input  logic        i_instr_rdy,
  output logic        o_fetch_err
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {FETCH, STALL, DRAIN, ERR} state_t;

  state_t        state_q, state_d;
  logic          live_q;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   tgt_q, tgt_d;
  logic          err_q, err_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] rd_q, wr_q;
  logic [31:0]   pc_mem    [FIFO_DEPTH];
  logic [31:0]   instr_mem [FIFO_DEPTH];
  logic          push, pop, flush, redir, misaligned;

  // live_q keeps the first request one cycle behind reset release.
  assign o_imem_req  = live_q && (state_q == FETCH || state_q == DRAIN);
  assign o_imem_addr = addr_q;
  assign o_instr_vld = (count_q != '0);
  assign o_instr     = instr_mem[rd_q];
  assign o_pc        = pc_mem[rd_q];
  assign o_fetch_err = err_q;

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d    = state_q;
    addr_d     = addr_q;
    tgt_d      = tgt_q;
    err_d      = err_q;
    push       = 1'b0;
    flush      = 1'b0;
    redir      = i_redirect && (state_q != ERR);
    misaligned = (i_redirect_pc[1:0] != 2'b00);
    pop        = o_instr_vld && i_instr_rdy && !redir;

    if (redir) begin
      flush = 1'b1;
      err_d = err_q | misaligned;
      if (o_imem_req && !i_imem_rvalid) begin
        // Old address stays on the bus until its response arrives and is dropped.
        state_d = DRAIN;
        tgt_d   = i_redirect_pc;
      end else begin
        state_d = (err_q || misaligned) ? ERR : FETCH;
        addr_d  = i_redirect_pc;
      end
    end else begin
      case (state_q)
        FETCH: if (o_imem_req && i_imem_rvalid) begin
          push   = 1'b1;
          addr_d = addr_q + 32'd4;
          if (count_q - CW'(pop) == FULL - CW'(1)) state_d = STALL;
        end
        STALL: if (pop) state_d = FETCH;
        DRAIN: if (i_imem_rvalid) begin
          state_d = err_q ? ERR : FETCH;
          addr_d  = tgt_q;
        end
        default: ;
      endcase
    end

    count_d = flush ? '0 : count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= FETCH;
      live_q  <= 1'b0;
      addr_q  <= RESET_PC;
      tgt_q   <= RESET_PC;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values whatever the statement order.
      state_q <= state_d;
      live_q  <= 1'b1;
      addr_q  <= addr_d;
      tgt_q   <= tgt_d;
      err_q   <= err_d;
      count_q <= count_d;
    end
  end

  // NOTE: storage is reset because o_instr/o_pc are driven straight from it and must read zero out of reset.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      rd_q <= '0;
      wr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem[i]    <= '0;
        instr_mem[i] <= '0;
      end
    end else if (flush) begin
      rd_q <= '0;
      wr_q <= '0;
    end else begin
      if (push) begin
        pc_mem[wr_q]    <= addr_q;
        instr_mem[wr_q] <= i_imem_rdata;
        wr_q            <= wr_q + AW'(1);
      end
      if (pop) rd_q <= rd_q + AW'(1);
    end
  end
endmodule

// File: tb/tb_ifetch_unit.sv
// Bench for ifetch_unit: directed scenarios plus random traffic, checked against
// an in-order instruction stream model and a variable-latency memory model.
module tb_ifetch_unit;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          FIFO_DEPTH = 2;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b1;
  logic        i_redirect = 1'b0;
  logic [31:0] i_redirect_pc = '0;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_rvalid = 1'b0;
  logic [31:0] i_imem_rdata = '0;
  logic        o_instr_vld;
  logic [31:0] o_instr;
  logic [31:0] o_pc;
  logic        i_instr_rdy = 1'b0;
  logic        o_fetch_err;

  int n_checks = 0;
  int n_fail   = 0;

  // Stream model: decode must see consecutive words from the last taken target.
  logic [31:0] exp_pc = RESET_PC;
  bit          model_err = 1'b0;
  int          n_accept = 0;

  // Memory model: one outstanding read, fixed or random latency.
  bit          mem_busy = 1'b0;
  bit          mem_rand = 1'b0;
  int          mem_lat  = 1;
  int          mem_wait = 0;
  logic [31:0] mem_addr = '0;

  ifetch_unit #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc),
    .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
    .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
    .o_instr_vld(o_instr_vld), .o_instr(o_instr), .o_pc(o_pc),
    .i_instr_rdy(i_instr_rdy), .o_fetch_err(o_fetch_err)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
  endfunction

  task automatic mem_drive();
    if (i_imem_rvalid) mem_busy = 1'b0;
    if (!i_reset || !o_imem_req) begin
      i_imem_rvalid = 1'b0;
      mem_busy = 1'b0;
      return;
    end
    if (!mem_busy) begin
      mem_busy = 1'b1;
      mem_addr = o_imem_addr;
      mem_wait = mem_rand ? int'($urandom_range(0, 3)) : mem_lat - 1;
    end else begin
      n_checks++;
      if (o_imem_addr !== mem_addr) begin
        n_fail++;
        $display("FAIL addr_hold: addr=%h required=%h", o_imem_addr, mem_addr);
      end
      mem_wait--;
    end
    i_imem_rvalid = (mem_wait == 0);
    i_imem_rdata  = i_imem_rvalid ? word_of(o_imem_addr) : $urandom();
  endtask

  // Called at a negedge with this cycle's inputs final; advances one clock.
  task automatic cycle();
    if (i_reset && o_instr_vld && i_instr_rdy && !i_redirect) begin
      n_checks++;
      if (model_err || o_pc !== exp_pc || o_instr !== word_of(exp_pc)) begin
        n_fail++;
        $display("FAIL stream: pc=%h instr=%h required pc=%h instr=%h (halted=%0d)",
                 o_pc, o_instr, exp_pc, word_of(exp_pc), model_err);
      end
      exp_pc = exp_pc + 32'd4;
      n_accept++;
    end
    if (i_reset && i_redirect && !model_err) begin
      if (i_redirect_pc[1:0] != 2'b00) model_err = 1'b1;
      else exp_pc = i_redirect_pc;
    end
    @(negedge i_clk);
    mem_drive();
  endtask

  task automatic apply_reset();
    i_reset = 1'b0;
    i_redirect = 1'b0;
    i_instr_rdy = 1'b0;
    i_imem_rvalid = 1'b0;
    mem_busy = 1'b0;
    mem_rand = 1'b0;
    repeat (2) @(negedge i_clk);
    i_reset = 1'b1;
    exp_pc = RESET_PC;
    model_err = 1'b0;
  endtask

  task automatic test_reset();
    #1 i_reset = 1'b0;
    repeat (2) @(negedge i_clk);
    n_checks++;
    if ({o_imem_req, o_instr_vld, o_fetch_err} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags: req/vld/err=%b required 000", {o_imem_req, o_instr_vld, o_fetch_err});
    end
    n_checks++;
    if (o_imem_addr !== RESET_PC || o_instr !== 32'h0 || o_pc !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: addr=%h instr=%h pc=%h required %h 0 0", o_imem_addr, o_instr, o_pc, RESET_PC);
    end
    i_reset = 1'b1;
    exp_pc = RESET_PC;
    mem_lat = 1;
    cycle();
    n_checks++;
    if (o_imem_req !== 1'b1 || o_imem_addr !== RESET_PC) begin
      n_fail++; $display("FAIL first_req: req=%b addr=%h required 1 %h", o_imem_req, o_imem_addr, RESET_PC);
    end
  endtask

  task automatic test_sequential();
    apply_reset();
    mem_lat = 1;
    i_instr_rdy = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      cycle();
      if (k <= 3) begin
        n_checks++;
        if (o_imem_req !== 1'b1 || o_imem_addr !== RESET_PC + 32'(4 * (k - 1))) begin
          n_fail++; $display("FAIL seq_addr[%0d]: req=%b addr=%h required 1 %h", k, o_imem_req, o_imem_addr, RESET_PC + 32'(4 * (k - 1)));
        end
      end
      if (k >= 2) begin
        n_checks++;
        if (o_instr_vld !== 1'b1 || o_pc !== RESET_PC + 32'(4 * (k - 2))) begin
          n_fail++; $display("FAIL seq_pc[%0d]: vld=%b pc=%h required 1 %h", k, o_instr_vld, o_pc, RESET_PC + 32'(4 * (k - 2)));
        end
      end
    end
  endtask

  task automatic test_stall();
    apply_reset();
    mem_lat = 1;
    repeat (3) cycle();
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (o_imem_req !== 1'b0 || o_instr_vld !== 1'b1 || o_pc !== RESET_PC) begin
        n_fail++; $display("FAIL stall_hold[%0d]: req=%b vld=%b pc=%h required 0 1 %h", k, o_imem_req, o_instr_vld, o_pc, RESET_PC);
      end
      if (k == 0) cycle();
    end
    i_instr_rdy = 1'b1;
    cycle();
    i_instr_rdy = 1'b0;
    n_checks++;
    if (o_imem_req !== 1'b1 || o_imem_addr !== RESET_PC + 32'd8 || o_pc !== RESET_PC + 32'd4) begin
      n_fail++; $display("FAIL stall_resume: req=%b addr=%h pc=%h required 1 %h %h", o_imem_req, o_imem_addr, o_pc, RESET_PC + 32'd8, RESET_PC + 32'd4);
    end
  endtask

  task automatic test_drain_redirect();
    int guard = 0;
    int held = 0;
    bit vld_seen = 1'b0;
    apply_reset();
    mem_lat = 3;
    i_instr_rdy = 1'b1;
    do begin cycle(); guard++; end while (!(o_imem_req && o_imem_addr == RESET_PC + 32'd8) && guard < 40);
    n_checks++;
    if (guard >= 40) begin n_fail++; $display("FAIL drain_setup: addr=%h required %h", o_imem_addr, RESET_PC + 32'd8); end
    i_redirect = 1'b1;
    i_redirect_pc = 32'h0000_0100;
    cycle();
    i_redirect = 1'b0;
    while (o_imem_addr == RESET_PC + 32'd8 && guard < 60) begin
      if (o_instr_vld !== 1'b0 || o_imem_req !== 1'b1) vld_seen = 1'b1;
      held++; guard++;
      cycle();
    end
    n_checks++;
    if (held != 2 || vld_seen) begin
      n_fail++; $display("FAIL drain_hold: held=%0d bad_cycle=%0d required 2 0", held, vld_seen);
    end
    n_checks++;
    if (o_imem_req !== 1'b1 || o_imem_addr !== 32'h0000_0100) begin
      n_fail++; $display("FAIL drain_target: req=%b addr=%h required 1 00000100", o_imem_req, o_imem_addr);
    end
    held = 0;
    while (o_instr_vld !== 1'b1 && held < 10) begin held++; cycle(); end
    n_checks++;
    if (held != 3 || o_pc !== 32'h0000_0100 || o_instr !== word_of(32'h0000_0100)) begin
      n_fail++; $display("FAIL drain_first: empty_cycles=%0d pc=%h instr=%h required 3 00000100 %h", held, o_pc, o_instr, word_of(32'h100));
    end
  endtask

  task automatic test_redirect_rvalid_pop();
    apply_reset();
    mem_lat = 1;
    i_instr_rdy = 1'b1;
    repeat (3) cycle();
    n_checks++;
    if (o_instr_vld !== 1'b1 || i_imem_rvalid !== 1'b1) begin
      n_fail++; $display("FAIL rrp_setup: vld=%b rvalid=%b required 1 1", o_instr_vld, i_imem_rvalid);
    end
    i_redirect = 1'b1;
    i_redirect_pc = 32'h0000_0040;
    cycle();
    i_redirect = 1'b0;
    n_checks++;
    if (o_instr_vld !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== 32'h0000_0040) begin
      n_fail++; $display("FAIL rrp_flush: vld=%b req=%b addr=%h required 0 1 00000040", o_instr_vld, o_imem_req, o_imem_addr);
    end
    cycle();
    n_checks++;
    if (o_instr_vld !== 1'b1 || o_pc !== 32'h0000_0040) begin
      n_fail++; $display("FAIL rrp_target: vld=%b pc=%h required 1 00000040", o_instr_vld, o_pc);
    end
  endtask

  task automatic test_wrap();
    apply_reset();
    mem_lat = 1;
    i_instr_rdy = 1'b1;
    repeat (2) cycle();
    i_redirect = 1'b1;
    i_redirect_pc = 32'hFFFF_FFF8;
    cycle();
    i_redirect = 1'b0;
    repeat (3) cycle();
    n_checks++;
    if (o_instr_vld !== 1'b1 || o_pc !== 32'h0000_0000 || o_imem_addr !== 32'h0000_0004) begin
      n_fail++; $display("FAIL wrap: vld=%b pc=%h addr=%h required 1 00000000 00000004", o_instr_vld, o_pc, o_imem_addr);
    end
  endtask

  task automatic test_misaligned();
    apply_reset();
    mem_lat = 2;
    i_instr_rdy = 1'b1;
    cycle();
    i_redirect = 1'b1;
    i_redirect_pc = 32'h0000_0102;
    cycle();
    i_redirect = 1'b0;
    n_checks++;
    if (o_fetch_err !== 1'b1 || o_instr_vld !== 1'b0 || o_imem_req !== 1'b1 || o_imem_addr !== RESET_PC) begin
      n_fail++; $display("FAIL mis_drain: err=%b vld=%b req=%b addr=%h required 1 0 1 %h", o_fetch_err, o_instr_vld, o_imem_req, o_imem_addr, RESET_PC);
    end
    cycle();
    n_checks++;
    if ({o_fetch_err, o_instr_vld, o_imem_req} !== 3'b100) begin
      n_fail++; $display("FAIL mis_halt: err/vld/req=%b required 100", {o_fetch_err, o_instr_vld, o_imem_req});
    end
    i_redirect = 1'b1;
    i_redirect_pc = 32'h0000_0200;
    cycle();
    i_redirect = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cycle();
      n_checks++;
      if ({o_fetch_err, o_instr_vld, o_imem_req} !== 3'b100) begin
        n_fail++; $display("FAIL mis_ignore[%0d]: err/vld/req=%b required 100", k, {o_fetch_err, o_instr_vld, o_imem_req});
      end
    end
  endtask

  task automatic test_async_reset();
    int guard = 0;
    apply_reset();
    mem_lat = 2;
    do begin cycle(); guard++; end while (!(o_instr_vld && !o_imem_req) && guard < 20);
    n_checks++;
    if (guard >= 20) begin n_fail++; $display("FAIL ares_setup: vld=%b req=%b required 1 0", o_instr_vld, o_imem_req); end
    #2 i_reset = 1'b0;
    #1;
    n_checks++;
    if ({o_imem_req, o_instr_vld, o_fetch_err} !== 3'b000 || o_pc !== 32'h0 || o_instr !== 32'h0 || o_imem_addr !== RESET_PC) begin
      n_fail++; $display("FAIL ares_clear: req/vld/err=%b pc=%h instr=%h addr=%h required 000 0 0 %h",
                         {o_imem_req, o_instr_vld, o_fetch_err}, o_pc, o_instr, o_imem_addr, RESET_PC);
    end
    i_imem_rvalid = 1'b0;
    mem_busy = 1'b0;
    @(negedge i_clk);
    i_reset = 1'b1;
    exp_pc = RESET_PC;
    model_err = 1'b0;
    cycle();
    n_checks++;
    if (o_imem_req !== 1'b1 || o_imem_addr !== RESET_PC) begin
      n_fail++; $display("FAIL ares_restart: req=%b addr=%h required 1 %h", o_imem_req, o_imem_addr, RESET_PC);
    end
  endtask

  task automatic test_random();
    int start;
    apply_reset();
    mem_rand = 1'b1;
    start = n_accept;
    for (int c = 0; c < 1500; c++) begin
      i_instr_rdy = ($urandom_range(0, 9) < 7);
      i_redirect = ($urandom_range(0, 29) == 0);
      i_redirect_pc = {20'h0, 10'($urandom_range(0, 1023)), 2'b00};
      cycle();
    end
    i_redirect = 1'b0;
    n_checks++;
    if (n_accept - start < 100 || o_fetch_err !== 1'b0) begin
      n_fail++; $display("FAIL random_progress: accepted=%0d err=%b required >=100 0", n_accept - start, o_fetch_err);
    end
    mem_rand = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_drain_redirect();
    test_redirect_rvalid_pop();
    test_wrap();
    test_misaligned();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
